// File: rtl/mcb_pkg.sv
// mcb_pkg: constants and types shared by the MCB command arbiter files.
//   MCB_FIFO_DEPTH : default depth (32-bit words) of the port data FIFOs
//   MCB_INSTR_WR/RD: controller command instruction encodings
//   arb_state_t    : arbiter FSM state encoding (also seen on dbg_state)
package mcb_pkg;

  localparam int MCB_FIFO_DEPTH = 64;

  localparam logic [2:0] MCB_INSTR_WR = 3'b000;
  localparam logic [2:0] MCB_INSTR_RD = 3'b001;

  typedef enum logic [1:0] {
    ST_WAIT_CALIB = 2'd0,
    ST_IDLE       = 2'd1,
    ST_ISSUE      = 2'd2,
    ST_GAP        = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mcb_rd_credit.sv
// mcb_rd_credit: tracks read-data words that have been requested from the
// controller but not yet popped by the consumer.
//   clk, rst_n     : port clock, asynchronous active-low reset
//   add_en, add_bl : a read command issues this cycle, burst length minus one
//   pop            : consumer pops one word from the read-data FIFO
//   credit         : words outstanding (registered)
//   err            : sticky; set on a pop at zero credit or on count overflow
module mcb_rd_credit #(
  parameter int BL_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            add_en,
  input  logic [BL_W-1:0] add_bl,
  input  logic            pop,
  output logic [6:0]      credit,
  output logic            err
);

  logic [7:0] add_amt;
  logic [7:0] sub_amt;
  logic [7:0] credit_nxt;
  logic       underflow;

  // Issue and pop in the same cycle combine into a single net update.
  // A pop at zero is dropped (counter saturates) and flagged.
  always_comb begin
    add_amt    = add_en ? (8'(add_bl) + 8'd1) : 8'd0;
    underflow  = pop && (credit == 7'd0);
    sub_amt    = (pop && !underflow) ? 8'd1 : 8'd0;
    credit_nxt = {1'b0, credit} + add_amt - sub_amt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= 7'd0;
      err    <= 1'b0;
    end else begin
      credit <= credit_nxt[6:0];
      // Bit 7 can only rise if the eligibility check was bypassed.
      if (underflow || credit_nxt[7]) err <= 1'b1;
    end
  end

endmodule

// File: rtl/mcb_cmd_arbiter.sv
// mcb_cmd_arbiter: shares one MCB command port between a burst writer and a
// burst reader. Writes wait for enough data in the write FIFO; reads wait for
// enough free space in the read FIFO (tracked by mcb_rd_credit).
//
// Build option: MCB_ARB_RD_PRIORITY_EN -- when defined, an eligible read
// always wins; otherwise requesters alternate round-robin.
//
// Ports:
//   clk, SYS_RESETn          : port clock, asynchronous active-low reset
//   mem_calib_done           : calibration complete
//   wr_req/wr_bl/wr_addr     : writer request, burst length-1, byte address
//   wr_gnt                   : one-cycle pulse when the write command issues
//   rd_req/rd_bl/rd_addr     : reader request, burst length-1, byte address
//   rd_gnt                   : one-cycle pulse when the read command issues
//   cmd_full, wr_count       : controller command-FIFO full, write FIFO fill
//   rd_pop                   : consumer popped one read-data word
//   cmd_en/cmd_instr/cmd_bl/cmd_byte_addr : command to the controller
//   rd_credit_used           : read words outstanding
//   err                      : sticky protocol error
//   dbg_state                : current FSM state
//
// Handshake: a requester holds req/bl/addr stable until its gnt pulse; the
// gnt cycle is the cycle cmd_en is presented to the controller.
module mcb_cmd_arbiter
  import mcb_pkg::*;
#(
  parameter int FIFO_DEPTH = MCB_FIFO_DEPTH,
  parameter int ADDR_W     = 30,
  parameter int BL_W       = 6
) (
  input  logic              clk,
  input  logic              SYS_RESETn,
  input  logic              mem_calib_done,
  input  logic              wr_req,
  input  logic [BL_W-1:0]   wr_bl,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [BL_W-1:0]   rd_bl,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  input  logic              cmd_full,
  input  logic [6:0]        wr_count,
  input  logic              rd_pop,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [BL_W-1:0]   cmd_bl,
  output logic [ADDR_W-1:0] cmd_byte_addr,
  output logic [6:0]        rd_credit_used,
  output logic              err,
  output logic [1:0]        dbg_state
);

  arb_state_t state, state_nxt;

  logic wr_elig;
  logic rd_elig;
  logic pick_rd;
  logic sel_rd_q;    // the command latched for ISSUE is a read
  logic issue_err;   // cmd_full seen while issuing
  logic credit_err;

`ifndef MCB_ARB_RD_PRIORITY_EN
  logic prefer_rd;   // round-robin: read goes first on the next tie
`endif

  // Sums kept at 8 bits so a 64-word burst on top of 64 credits cannot wrap.
  always_comb begin
    wr_elig = wr_req && !cmd_full &&
              ({1'b0, wr_count} >= (8'(wr_bl) + 8'd1));
    rd_elig = rd_req && !cmd_full &&
              (({1'b0, rd_credit_used} + 8'(rd_bl) + 8'd1) <= 8'(FIFO_DEPTH));
  end

  always_comb begin
`ifdef MCB_ARB_RD_PRIORITY_EN
    pick_rd = rd_elig;
`else
    pick_rd = rd_elig && (!wr_elig || prefer_rd);
`endif
  end

  // State register
  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn) state <= ST_WAIT_CALIB;
    else             state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_WAIT_CALIB: if (mem_calib_done) state_nxt = ST_IDLE;
      ST_IDLE:       if (wr_elig || rd_elig) state_nxt = ST_ISSUE;
      ST_ISSUE:      state_nxt = ST_GAP;
      ST_GAP:        state_nxt = mem_calib_done ? ST_IDLE : ST_WAIT_CALIB;
      default:       state_nxt = ST_WAIT_CALIB;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_en    = (state == ST_ISSUE);
    wr_gnt    = cmd_en && !sel_rd_q;
    rd_gnt    = cmd_en &&  sel_rd_q;
    dbg_state = state;
  end

  // Command fields are captured at the IDLE decision so they are stable and
  // registered during ISSUE; they hold their value afterwards.
  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn) begin
      sel_rd_q      <= 1'b0;
      cmd_instr     <= 3'b000;
      cmd_bl        <= '0;
      cmd_byte_addr <= '0;
    end else if (state == ST_IDLE && (wr_elig || rd_elig)) begin
      sel_rd_q      <= pick_rd;
      cmd_instr     <= pick_rd ? MCB_INSTR_RD : MCB_INSTR_WR;
      cmd_bl        <= pick_rd ? rd_bl   : wr_bl;
      cmd_byte_addr <= pick_rd ? rd_addr : wr_addr;
    end
  end

`ifndef MCB_ARB_RD_PRIORITY_EN
  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn)            prefer_rd <= 1'b0;
    else if (state == ST_ISSUE) prefer_rd <= !sel_rd_q;
  end
`endif

  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn)                          issue_err <= 1'b0;
    else if (state == ST_ISSUE && cmd_full)   issue_err <= 1'b1;
  end

  mcb_rd_credit #(
    .BL_W (BL_W)
  ) u_rd_credit (
    .clk    (clk),
    .rst_n  (SYS_RESETn),
    .add_en (rd_gnt),
    .add_bl (cmd_bl),
    .pop    (rd_pop),
    .credit (rd_credit_used),
    .err    (credit_err)
  );

  assign err = issue_err || credit_err;

endmodule

// File: doc/mcb_cmd_arbiter.md
# mcb_cmd_arbiter

Shares one DDR2 memory-controller command port between a burst writer (the render-side frame writer) and a burst reader (the display-side line fetcher). Arbitrates requests, gates write commands on write-FIFO fill level, and gates read commands on free space in the read-data FIFO using a credit counter, so the port never underruns a write or overflows a read. Sits between the port controllers and the videoRam port's command/FIFO signals, in that port's clock domain.

## Interface
- FIFO_DEPTH, 64, depth in 32-bit words of the port's read and write data FIFOs
- ADDR_W, 30, byte-address width
- BL_W, 6, burst-length field width; the field encodes words minus one
- clk  in  1  port clock; all logic is on its rising edge
- SYS_RESETn  in  1  asynchronous, active-low reset
- mem_calib_done  in  1  memory calibration complete
- wr_req  in  1  writer requests a write command
- wr_bl  in  BL_W  writer burst length minus one
- wr_addr  in  ADDR_W  writer byte address
- wr_gnt  out  1  one-cycle pulse: write command issued
- rd_req  in  1  reader requests a read command
- rd_bl  in  BL_W  reader burst length minus one
- rd_addr  in  ADDR_W  reader byte address
- rd_gnt  out  1  one-cycle pulse: read command issued
- cmd_full  in  1  controller command FIFO full
- wr_count  in  7  words currently in the write-data FIFO
- rd_pop  in  1  the consumer asserted rd_en on the read-data FIFO this cycle
- cmd_en  out  1  command strobe to the controller
- cmd_instr  out  3  3'b000 for write, 3'b001 for read
- cmd_bl  out  BL_W  burst length minus one
- cmd_byte_addr  out  ADDR_W  command byte address
- rd_credit_used  out  7  read words issued but not yet popped (range 0..FIFO_DEPTH)
- err  out  1  sticky protocol error

## Operation
- All outputs reset to 0. Reset is asynchronous and may be asserted mid-operation; it returns the block to WAIT_CALIB and clears the credit counter and the round-robin pointer.
- States:
  - WAIT_CALIB: leave when mem_calib_done=1. Go to IDLE.
  - IDLE: evaluate eligibility. If any request is eligible, go to ISSUE.
  - ISSUE: cmd_en=1 together with the matching gnt. Go to GAP.
  - GAP: one dead cycle so cmd_full can update. Go to IDLE, or to WAIT_CALIB if mem_calib_done=0.
- Write eligibility: wr_req & !cmd_full & (wr_count >= wr_bl+1).
- Read eligibility: rd_req & !cmd_full & (rd_credit_used + rd_bl + 1 <= FIFO_DEPTH). Compute the sum at 8 bits so it cannot wrap.
- Arbitration when both requests are eligible:
  - Round-robin. Grant the requester that did not receive the last grant.
  - The pointer updates only on an issued command.
- A requester holds req, bl and addr stable until it sees its gnt. It may drop req after gnt or re-assert req the following cycle.
- Credit counter:
  - Adds rd_bl+1 in the ISSUE cycle of a read.
  - Subtracts 1 on each rd_pop.
  - On a simultaneous issue and pop, the net change is applied in one cycle.
  - A pop when the counter is 0 leaves it at 0 and sets err.
- err is also set if cmd_full=1 in the ISSUE cycle. err clears only on reset.

## Timing
- Registered decision: a request eligible in IDLE at cycle N produces cmd_en/gnt in cycle N+1 (latency 1). cmd_instr, cmd_bl and cmd_byte_addr are valid in that same cycle.
- Minimum command spacing is 3 cycles (ISSUE, GAP, IDLE).
- cmd_full, wr_count and the credit counter are sampled in IDLE only. A change during ISSUE or GAP affects the next decision.
- rd_credit_used is registered and updates one cycle after the triggering pop or issue.

## Configuration
- MCB_ARB_RD_PRIORITY_EN defined:
  - An eligible read always wins over an eligible write, so the display cannot underrun.
  - The round-robin pointer is unused.
- MCB_ARB_RD_PRIORITY_EN undefined: round-robin as described above.

## Structure
- Shared package mcb_pkg holds:
  - the instruction constants MCB_INSTR_WR=3'b000 and MCB_INSTR_RD=3'b001;
  - the arbiter state enum;
  - the default FIFO_DEPTH.
- The credit counter is a natural sub-module, mcb_rd_credit: add-by-bl, subtract-by-pop, saturating at 0 with an error flag.

## Test plan
- Calibration gating: mem_calib_done=0 with wr_req=1, wr_count=64 → no cmd_en. Raise mem_calib_done → cmd_en with instr 000 two cycles later.
- Write gating: wr_bl=15, wr_count=15 → no grant. Set wr_count=16 → wr_gnt, with cmd_bl=15 and cmd_byte_addr equal to wr_addr.
- Read credit: issue four reads with rd_bl=15 and no pops → rd_credit_used=64 and a fifth read is blocked. Pop 16 words → the fifth read is granted and the counter returns to 64.
- Arbitration with both requesters eligible continuously:
  - Grants alternate wr, rd, wr, rd at a 3-cycle spacing.
  - With MCB_ARB_RD_PRIORITY_EN defined, only rd is granted.
- Boundaries:
  - A pop at rd_credit_used=0 → counter stays 0 and err=1.
  - A simultaneous pop and read issue with rd_bl=7 at counter 10 → 17.
  - Asserting SYS_RESETn=0 during ISSUE → all outputs 0 immediately.
